// File: rtl/memctrl_pkg.sv
// rtl/memctrl_pkg.sv - shared size encodings, FSM state type and byte-count helper for memctrl_mc
package memctrl_pkg;

  localparam logic [1:0] SZ_BYTE  = 2'd0;
  localparam logic [1:0] SZ_HALF  = 2'd1;
  localparam logic [1:0] SZ_WORD  = 2'd2;
  localparam logic [1:0] SZ_DWORD = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } state_t;

  // Bytes moved for a request, clamped to what the data bus can carry.
  function automatic logic [3:0] nbytes(input logic [1:0] size, input int data_w);
    int n;
    case (size)
      SZ_BYTE:  n = 1;
      SZ_HALF:  n = 2;
      SZ_WORD:  n = 4;
      SZ_DWORD: n = 8;
      default:  n = 1;
    endcase
    if (n > data_w / 8) n = data_w / 8;
    return 4'(n);
  endfunction

endpackage

// File: rtl/mem_arb.sv
// rtl/mem_arb.sv - one-hot request arbiter with fixed-priority or round-robin selection
module mem_arb #(
  parameter int NUM_CH = 2,
  parameter int ARB_RR = 0,
  localparam int PW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] req,
  input  logic              accept,
  output logic [NUM_CH-1:0] grant,
  output logic [PW-1:0]     win_idx
);

  logic [PW-1:0] ptr;

  // Search starts at ptr in round-robin mode, at channel 0 otherwise.
  always_comb begin : pick
    int   idx;
    logic found;
    grant   = '0;
    win_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = (ARB_RR != 0) ? int'(ptr) + i : i;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        win_idx    = PW'(idx);
        found      = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (accept) begin
      ptr <= (int'(win_idx) == NUM_CH - 1) ? '0 : win_idx + PW'(1);
    end
  end

endmodule

// File: rtl/memctrl_mc.sv
// rtl/memctrl_mc.sv - multi-channel arbiter and little-endian byte serialiser onto an 8-bit RAM port
module memctrl_mc
  import memctrl_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1,
  parameter int ARB_RR = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rdy,
  input  logic [NUM_CH-1:0]        ch_valid_i,
  input  logic [NUM_CH-1:0]        ch_we_i,
  input  logic [2*NUM_CH-1:0]      ch_size_i,
  input  logic [NUM_CH-1:0]        ch_sign_i,
  input  logic [ADDR_W*NUM_CH-1:0] ch_addr_i,
  input  logic [DATA_W*NUM_CH-1:0] ch_wdata_i,
  input  logic [NUM_CH-1:0]        ch_abort_i,
  output logic                     busy_o,
  output logic [NUM_CH-1:0]        grant_o,
  output logic [NUM_CH-1:0]        resp_valid_o,
  output logic [DATA_W-1:0]        resp_data_o,
  output logic                     ram_wr_o,
  output logic [ADDR_W-1:0]        ram_addr_o,
  output logic [7:0]               ram_data_o,
  input  logic [7:0]               ram_data_i
);

  localparam int NB = DATA_W / 8;
  localparam int PW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  state_t              state;
  logic [NUM_CH-1:0]   owner, grant;
  logic [PW-1:0]       win_idx;
  logic [ADDR_W-1:0]   addr_q, win_addr;
  logic [DATA_W-1:0]   wdata_q, win_wdata, asm_q, asm_next, read_result;
  logic [3:0]          cnt, cap_cnt, n_q, win_n;
  logic                sign_q, issue, accept, win_we, aborted, sbit;
  logic [RD_LAT-1:0]   pipe;

  mem_arb #(.NUM_CH(NUM_CH), .ARB_RR(ARB_RR)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (ch_valid_i & ~ch_abort_i),
    .accept  (accept),
    .grant   (grant),
    .win_idx (win_idx)
  );

  assign accept    = rdy && (state == IDLE) && (|grant);
  assign win_addr  = ch_addr_i[ADDR_W*int'(win_idx) +: ADDR_W];
  assign win_wdata = ch_wdata_i[DATA_W*int'(win_idx) +: DATA_W];
  assign win_we    = ch_we_i[win_idx];
  assign win_n     = nbytes(ch_size_i[2*int'(win_idx) +: 2], DATA_W);
  assign aborted   = |(ch_abort_i & owner);
  assign busy_o    = (state != IDLE);
  assign grant_o   = busy_o ? owner : '0;

  // Byte 0 goes out combinationally in the accept cycle; later bytes come from addr_q/wdata_q.
  always_comb begin
    ram_addr_o = addr_q;
    ram_data_o = wdata_q[7:0];
    ram_wr_o   = 1'b0;
    issue      = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          ram_addr_o = win_addr;
          ram_data_o = win_wdata[7:0];
          ram_wr_o   = win_we;
          issue      = !win_we;
        end
      end
      READ:    issue    = (cnt < n_q);
      WRITE:   ram_wr_o = rdy;
      default: ;
    endcase
  end

  always_comb begin
    asm_next = asm_q;
    asm_next[8*int'(cap_cnt) +: 8] = ram_data_i;
    sbit = sign_q && (n_q != 4'd0) && asm_next[8*int'(n_q)-1];
    read_result = asm_next;
    for (int b = 0; b < NB; b++) begin
      if (b >= int'(n_q)) read_result[8*b +: 8] = {8{sbit}};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      owner        <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      asm_q        <= '0;
      cnt          <= '0;
      cap_cnt      <= '0;
      n_q          <= '0;
      sign_q       <= 1'b0;
      pipe         <= '0;
      resp_valid_o <= '0;
      resp_data_o  <= '0;
    end else if (rdy) begin
      resp_valid_o <= '0;
      pipe         <= RD_LAT'({pipe, issue});
      case (state)
        IDLE: begin
          if (accept) begin
            owner   <= grant;
            n_q     <= win_n;
            sign_q  <= ch_sign_i[win_idx];
            addr_q  <= win_addr + ADDR_W'(1);
            cnt     <= 4'd1;
            cap_cnt <= '0;
            asm_q   <= '0;
            wdata_q <= win_wdata >> 8;
            if (!win_we) begin
              state <= READ;
            end else if (win_n != 4'd1) begin
              state <= WRITE;
            end else begin
              resp_valid_o <= grant;
              resp_data_o  <= '0;
            end
          end
        end
        READ: begin
          // Clearing the pipe drops bytes still in flight from the aborted read.
          if (aborted) begin
            state <= IDLE;
            pipe  <= '0;
          end else begin
            if (issue) begin
              addr_q <= addr_q + ADDR_W'(1);
              cnt    <= cnt + 4'd1;
            end
            if (pipe[RD_LAT-1]) begin
              asm_q   <= asm_next;
              cap_cnt <= cap_cnt + 4'd1;
              if (cap_cnt == n_q - 4'd1) begin
                state        <= IDLE;
                resp_valid_o <= owner;
                resp_data_o  <= read_result;
              end
            end
          end
        end
        WRITE: begin
          addr_q  <= addr_q + ADDR_W'(1);
          cnt     <= cnt + 4'd1;
          wdata_q <= wdata_q >> 8;
          if (cnt == n_q - 4'd1) begin
            state        <= IDLE;
            resp_valid_o <= owner;
            resp_data_o  <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
